// File: rtl/sb_pkg.sv
// Shared definitions for Gecko5 system-bus responders: FSM states, widths and window size.
package sb_pkg;

    localparam int unsigned SbWindowWords  = 16;
    localparam int unsigned SbScratchWords = SbWindowWords - 1;
    localparam int unsigned SbIndexW       = 4;
    localparam int unsigned SbCountW       = 5;
    localparam int unsigned SbBurstW       = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StRdEnd,
        StWrite,
        StErr,
        StWdrain
    } sb_state_e;

    // True when a burst starting at index would run past the last word of the window.
    function automatic logic burst_overruns(input logic [SbIndexW-1:0] index,
                                            input logic [SbBurstW-1:0] burst);
        logic [SbBurstW:0] last_index;
        last_index = {{(SbBurstW + 1 - SbIndexW){1'b0}}, index} + {1'b0, burst};
        return last_index > (SbBurstW + 1)'(SbWindowWords - 1);
    endfunction

endpackage

// File: rtl/sb_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new data, others keep the old word.
module sb_byte_merge #(
    parameter int unsigned Bytes = 4
) (
    input  logic [8*Bytes-1:0] old_word_i,
    input  logic [8*Bytes-1:0] new_word_i,
    input  logic [Bytes-1:0]   byte_en_i,
    output logic [8*Bytes-1:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int unsigned b = 0; b < Bytes; b++) begin
            if (byte_en_i[b]) begin
                merged_o[8*b +: 8] = new_word_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/sb_debug_mailbox.sv
// Debug mailbox responder: 15 scratch words plus a read-only ID word on the system bus.
// Define SB_DEBUG_MAILBOX_DOORBELL_EN to add irq_o, raised by writes to word 0.
module sb_debug_mailbox
    import sb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hDB60_0001
) (
    input  logic        sb_clock_i,
    input  logic        sb_reset_n_i,
    input  logic        sb_begin_transaction_i,
    input  logic [31:0] sb_address_data_i,
    input  logic [3:0]  sb_byte_enables_i,
    input  logic [7:0]  sb_burst_size_i,
    input  logic        sb_read_n_write_i,
    input  logic        sb_data_valid_i,
    input  logic        sb_end_transaction_i,
    input  logic        sb_busy_i,
    output logic [31:0] sb_address_data_o,
    output logic        sb_data_valid_o,
    output logic        sb_end_transaction_o,
    output logic        sb_error_o,
    output logic        sb_busy_o
`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
    ,
    output logic        irq_o
`endif
);

    localparam logic [SbIndexW-1:0] IdIndex = SbIndexW'(SbScratchWords);

    sb_state_e             state_q, state_d;
    logic [SbIndexW-1:0]   index_q, index_d;
    logic [SbCountW-1:0]   count_q, count_d;
    logic [3:0]            be_q, be_d;
    logic                  rnw_q, rnw_d;
    logic [31:0]           mailbox_q [SbScratchWords];

    logic [31:0]           rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  end_q, end_d;
    logic                  err_q, err_d;

    logic                  select;
    logic                  wr_en;
    logic [31:0]           cur_word;
    logic [31:0]           next_word;
    logic [31:0]           merged_word;

    assign select = sb_begin_transaction_i && (sb_address_data_i[31:6] == BASE_ADDR[31:6]);

    always_comb begin
        cur_word = (index_q == IdIndex) ? ID_VALUE : mailbox_q[index_q];
    end

    always_comb begin
        next_word = (index_d == IdIndex) ? ID_VALUE : mailbox_q[index_d];
    end

    sb_byte_merge #(
        .Bytes(4)
    ) u_byte_merge (
        .old_word_i(cur_word),
        .new_word_i(sb_address_data_i),
        .byte_en_i (be_q),
        .merged_o  (merged_word)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        be_d    = be_q;
        rnw_d   = rnw_q;
        wr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (select) begin
                    index_d = sb_address_data_i[5:2];
                    be_d    = sb_byte_enables_i;
                    rnw_d   = sb_read_n_write_i;
                    count_d = SbCountW'(sb_burst_size_i[SbIndexW-1:0]) + SbCountW'(1);
                    if (burst_overruns(sb_address_data_i[5:2], sb_burst_size_i)) begin
                        state_d = StErr;
                    end else if (sb_read_n_write_i) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                if (!sb_busy_i) begin
                    if (count_q == SbCountW'(1)) begin
                        state_d = StRdEnd;
                    end else begin
                        index_d = index_q + SbIndexW'(1);
                        count_d = count_q - SbCountW'(1);
                    end
                end
            end
            StRdEnd: begin
                state_d = StIdle;
            end
            StWrite: begin
                // Beats past the burst length arrive with count_q == 0 and are dropped.
                if (sb_data_valid_i && (count_q != '0)) begin
                    wr_en   = (index_q != IdIndex);
                    index_d = index_q + SbIndexW'(1);
                    count_d = count_q - SbCountW'(1);
                end
                if (sb_end_transaction_i) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (rnw_q || sb_end_transaction_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWdrain;
                end
            end
            StWdrain: begin
                if (sb_end_transaction_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        valid_d = (state_d == StRead);
        rdata_d = valid_d ? next_word : '0;
        end_d   = (state_d == StRdEnd) || (state_d == StErr);
        err_d   = (state_d == StErr);
    end

    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            state_q <= StIdle;
            index_q <= '0;
            count_q <= '0;
            be_q    <= '0;
            rnw_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < SbScratchWords; i++) begin
                mailbox_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            be_q    <= be_d;
            rnw_q   <= rnw_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            err_q   <= err_d;
            if (wr_en) begin
                mailbox_q[index_q] <= merged_word;
            end
        end
    end

    assign sb_address_data_o    = rdata_q;
    assign sb_data_valid_o      = valid_q;
    assign sb_end_transaction_o = end_q;
    assign sb_error_o           = err_q;
    assign sb_busy_o            = 1'b0;

`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
    logic irq_q, irq_d;

    // A doorbell ring and an acknowledge in the same cycle leave the doorbell raised.
    always_comb begin
        irq_d = irq_q;
        if ((state_q == StRead) && !sb_busy_i && (index_q == '0)) begin
            irq_d = 1'b0;
        end
        if (wr_en && (index_q == '0) && (be_q != '0)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_sb_debug_mailbox.sv
// Self-checking bench for sb_debug_mailbox against a word-array reference of the window.
module tb_sb_debug_mailbox;

    localparam logic [31:0] BASE = 32'h5000_0000;
    localparam logic [31:0] ID   = 32'hDB60_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sb_begin;
    logic [31:0] sb_ad;
    logic [3:0]  sb_be;
    logic [7:0]  sb_burst;
    logic        sb_rnw;
    logic        sb_dv;
    logic        sb_end;
    logic        sb_busy;
    logic [31:0] ad_o;
    logic        dv_o;
    logic        end_o;
    logic        err_o;
    logic        busy_o;
`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    sb_debug_mailbox #(
        .BASE_ADDR(BASE),
        .ID_VALUE (ID)
    ) dut (
        .sb_clock_i            (clk),
        .sb_reset_n_i          (rst_n),
        .sb_begin_transaction_i(sb_begin),
        .sb_address_data_i     (sb_ad),
        .sb_byte_enables_i     (sb_be),
        .sb_burst_size_i       (sb_burst),
        .sb_read_n_write_i     (sb_rnw),
        .sb_data_valid_i       (sb_dv),
        .sb_end_transaction_i  (sb_end),
        .sb_busy_i             (sb_busy),
        .sb_address_data_o     (ad_o),
        .sb_data_valid_o       (dv_o),
        .sb_end_transaction_o  (end_o),
        .sb_error_o            (err_o),
        .sb_busy_o             (busy_o)
`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
        ,
        .irq_o                 (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [16];
    logic [31:0] wbuf [32];
    logic [31:0] cap_data [64];
    int          cap_cyc [64];
    int          cap_n;
    int          end_cyc;
    logic        end_err;
    logic        stray_data;
    logic [31:0] exp_data [64];
    int          exp_cyc [64];
    int          exp_n;
    int          exp_end;
    logic        w_err, w_end, w_valid;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        sb_begin = 1'b0; sb_ad = '0; sb_be = '0; sb_burst = '0;
        sb_rnw = 1'b0; sb_dv = 1'b0; sb_end = 1'b0; sb_busy = 1'b0;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 15; i++) mem[i] = '0;
        mem[15] = ID;
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] lane;
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            lane = 32'hFF << (8 * b);
            if (be[b]) r = (r & ~lane) | (new_w & lane);
        end
        return r;
    endfunction

    // Reference effect of a write transaction on the window.
    function automatic void model_write(input logic [31:0] addr, input int burst, input int nsend,
                                        input logic [3:0] be);
        int idx;
        if (addr[31:6] != BASE[31:6]) return;
        idx = int'(addr[5:2]);
        if (idx + burst > 15) return;
        for (int i = 0; i < nsend && i <= burst; i++) begin
            if (idx + i != 15) mem[idx + i] = merge_ref(mem[idx + i], wbuf[i], be);
        end
    endfunction

    // Expected beat sequence: each beat repeats for every busy cycle it meets, then moves on.
    function automatic void build_expected(input int idx, input int n, input logic [63:0] mask);
        int c;
        c = 1;
        exp_n = 0;
        for (int b = 0; b < n; b++) begin
            while (mask[c]) begin
                exp_data[exp_n] = mem[idx + b]; exp_cyc[exp_n] = c; exp_n++; c++;
            end
            exp_data[exp_n] = mem[idx + b]; exp_cyc[exp_n] = c; exp_n++; c++;
        end
        exp_end = c;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int burst, input int nsend,
                            input logic [3:0] be);
        sb_begin = 1'b1; sb_ad = addr; sb_be = be; sb_burst = 8'(burst); sb_rnw = 1'b0;
        step();
        w_err = err_o; w_end = end_o; w_valid = dv_o;
        sb_begin = 1'b0; sb_be = '0; sb_burst = '0;
        for (int i = 0; i < nsend; i++) begin
            sb_ad = wbuf[i]; sb_dv = 1'b1; sb_end = (i == nsend - 1);
            step();
            w_valid = w_valid | dv_o;
        end
        sb_ad = '0; sb_dv = 1'b0; sb_end = 1'b0;
        model_write(addr, burst, nsend, be);
    endtask

    task automatic run_read(input logic [31:0] addr, input int burst, input logic [63:0] mask);
        sb_begin = 1'b1; sb_ad = addr; sb_burst = 8'(burst); sb_rnw = 1'b1; sb_be = '0;
        step();
        sb_begin = 1'b0; sb_ad = '0; sb_burst = '0; sb_rnw = 1'b0;
        cap_n = 0; end_cyc = -1; end_err = 1'b0; stray_data = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            sb_busy = mask[c];
            if (dv_o) begin
                if (cap_n < 64) begin
                    cap_data[cap_n] = ad_o; cap_cyc[cap_n] = c; cap_n++;
                end
            end else if (ad_o !== 32'h0) begin
                stray_data = 1'b1;
            end
            if (err_o) end_err = 1'b1;
            if (end_o) begin
                end_cyc = c;
                break;
            end
            step();
        end
        sb_busy = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        step(); step();
        n_checks++;
        if ({ad_o, dv_o, end_o, err_o, busy_o} !== 36'h0)
            $display("FAIL reset_outputs: got %h required 0", {ad_o, dv_o, end_o, err_o, busy_o});
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 15; i++) wbuf[i] = $urandom | 32'h1;
        do_write(BASE, 14, 15, 4'hF);
        // Abandon a read burst partway through.
        sb_begin = 1'b1; sb_ad = BASE; sb_burst = 8'd7; sb_rnw = 1'b1;
        step();
        bus_idle();
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({ad_o, dv_o, end_o, err_o, busy_o} !== 36'h0)
            $display("FAIL midread_reset_outputs: got %h required 0",
                     {ad_o, dv_o, end_o, err_o, busy_o});
`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b required 0", irq);
        end
`endif
        rst_n = 1'b1;
        model_reset();
        step();
        run_read(BASE, 15, '0);
        n_checks++;
        if (cap_n !== 16) begin
            n_fail++; $display("FAIL reset_readback_len: got %0d required 16", cap_n);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_data[i] !== mem[i]) begin
                n_fail++;
                $display("FAIL reset_readback[%0d]: got %h required %h", i, cap_data[i], mem[i]);
            end
        end
    endtask

    task automatic test_burst_rw();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(BASE + 32'h8, 3, 4, 4'hF);
        n_checks++;
        if (w_err !== 1'b0 || w_valid !== 1'b0) begin
            n_fail++; $display("FAIL burst_write_resp: got err %b valid %b required 0 0",
                               w_err, w_valid);
        end
        run_read(BASE + 32'h8, 3, '0);
        n_checks++;
        if (cap_n !== 4 || end_cyc !== 5 || stray_data !== 1'b0) begin
            n_fail++; $display("FAIL burst_read_shape: got beats %0d end %0d stray %b required 4 5 0",
                               cap_n, end_cyc, stray_data);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_data[i] !== 32'(i + 1) || cap_cyc[i] !== i + 1) begin
                n_fail++; $display("FAIL burst_read_beat[%0d]: got %h@%0d required %h@%0d",
                                   i, cap_data[i], cap_cyc[i], i + 1, i + 1);
            end
        end
    endtask

    task automatic test_byte_merge();
        int idx;
        logic [3:0] be;
        idx = $urandom_range(0, 14);
        wbuf[0] = 32'h1122_3344;
        do_write(BASE + 32'(idx * 4), 0, 1, 4'hF);
        wbuf[0] = 32'hAABB_CCDD;
        do_write(BASE + 32'(idx * 4), 0, 1, 4'b0101);
        run_read(BASE + 32'(idx * 4), 0, '0);
        n_checks++;
        if (cap_n !== 1 || cap_data[0] !== 32'h11BB_33DD) begin
            n_fail++; $display("FAIL merge_0101: got %h (%0d beats) required 11bb33dd",
                               cap_data[0], cap_n);
        end
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 14);
            be = 4'($urandom);
            wbuf[0] = $urandom;
            do_write(BASE + 32'(idx * 4), 0, 1, be);
            run_read(BASE + 32'(idx * 4), 0, '0);
            n_checks++;
            if (cap_n !== 1 || cap_data[0] !== mem[idx]) begin
                n_fail++; $display("FAIL merge_rand[%0d] be %b: got %h required %h",
                                   idx, be, cap_data[0], mem[idx]);
            end
        end
    endtask

    task automatic test_busy();
        int idx, burst;
        logic [63:0] mask;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                idx = 5; burst = 2; mask = 64'b1100;
                for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
                do_write(BASE + 32'h14, 2, 3, 4'hF);
            end else begin
                idx = $urandom_range(0, 15);
                burst = $urandom_range(0, 15 - idx);
                mask = {40'h0, 24'($urandom)};
            end
            build_expected(idx, burst + 1, mask);
            run_read(BASE + 32'(idx * 4), burst, mask);
            n_checks++;
            if (cap_n !== exp_n || end_cyc !== exp_end) begin
                n_fail++; $display("FAIL busy_shape[%0d]: got beats %0d end %0d required %0d %0d",
                                   k, cap_n, end_cyc, exp_n, exp_end);
            end
            for (int i = 0; i < exp_n; i++) begin
                n_checks++;
                if (cap_data[i] !== exp_data[i] || cap_cyc[i] !== exp_cyc[i]) begin
                    n_fail++; $display("FAIL busy_beat[%0d.%0d]: got %h@%0d required %h@%0d",
                                       k, i, cap_data[i], cap_cyc[i], exp_data[i], exp_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_range_error();
        int idx, burst;
        run_read(BASE + 32'h3C, 1, '0);
        n_checks++;
        if (end_cyc !== 1 || end_err !== 1'b1 || cap_n !== 0) begin
            n_fail++; $display("FAIL err_read_idx15: got end %0d err %b beats %0d required 1 1 0",
                               end_cyc, end_err, cap_n);
        end
        wbuf[0] = $urandom; wbuf[1] = $urandom;
        do_write(BASE + 32'h3C, 1, 2, 4'hF);
        n_checks++;
        if (w_err !== 1'b1 || w_end !== 1'b1 || w_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_write_idx15: got err %b end %b valid %b required 1 1 0",
                               w_err, w_end, w_valid);
        end
        wbuf[0] = $urandom;
        do_write(BASE + 32'h3C, 0, 1, 4'hF);
        n_checks++;
        if (w_err !== 1'b0) begin
            n_fail++; $display("FAIL id_write_err: got %b required 0", w_err);
        end
        run_read(BASE + 32'h3C, 0, '0);
        n_checks++;
        if (cap_n !== 1 || cap_data[0] !== ID) begin
            n_fail++; $display("FAIL id_word: got %h required %h", cap_data[0], ID);
        end
        for (int k = 0; k < 6; k++) begin
            idx = $urandom_range(0, 15);
            burst = 16 - idx + $urandom_range(0, 200);
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            if (k % 2 == 0) begin
                run_read(BASE + 32'(idx * 4), burst, '0);
                n_checks++;
                if (end_cyc !== 1 || end_err !== 1'b1 || cap_n !== 0) begin
                    n_fail++; $display("FAIL err_read_rand[%0d+%0d]: got end %0d err %b beats %0d",
                                       idx, burst, end_cyc, end_err, cap_n);
                end
            end else begin
                do_write(BASE + 32'(idx * 4), burst, 4, 4'hF);
                n_checks++;
                if (w_err !== 1'b1 || w_end !== 1'b1) begin
                    n_fail++; $display("FAIL err_write_rand[%0d+%0d]: got err %b end %b",
                                       idx, burst, w_err, w_end);
                end
            end
        end
        run_read(BASE, 15, '0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_data[i] !== mem[i]) begin
                n_fail++; $display("FAIL err_unchanged[%0d]: got %h required %h",
                                   i, cap_data[i], mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx, burst, nsend;
        for (int k = 0; k < 12; k++) begin
            idx = $urandom_range(0, 15);
            burst = $urandom_range(0, 15 - idx);
            nsend = $urandom_range(1, burst + 3);
            for (int i = 0; i < nsend; i++) wbuf[i] = $urandom;
            do_write(BASE + 32'(idx * 4), burst, nsend, 4'($urandom));
            if (k % 3 == 2) begin
                run_read(BASE + 32'(idx * 4), burst, '0);
                for (int i = 0; i <= burst; i++) begin
                    n_checks++;
                    if (cap_data[i] !== mem[idx + i] || cap_cyc[i] !== i + 1) begin
                        n_fail++; $display("FAIL b2b_read[%0d.%0d]: got %h@%0d required %h@%0d",
                                           k, i, cap_data[i], cap_cyc[i], mem[idx + i], i + 1);
                    end
                end
            end
        end
        run_read(BASE, 15, '0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_data[i] !== mem[i]) begin
                n_fail++; $display("FAIL b2b_window[%0d]: got %h required %h",
                                   i, cap_data[i], mem[i]);
            end
        end
    endtask

    task automatic test_unselected();
        logic [31:0] addrs [2];
        addrs[0] = BASE + 32'h40;
        addrs[1] = BASE - 32'h4;
        for (int k = 0; k < 2; k++) begin
            run_read(addrs[k], 0, '0);
            n_checks++;
            if (end_cyc !== -1 || cap_n !== 0 || stray_data !== 1'b0 || end_err !== 1'b0) begin
                n_fail++; $display("FAIL unsel_read[%h]: got end %0d beats %0d stray %b err %b",
                                   addrs[k], end_cyc, cap_n, stray_data, end_err);
            end
            wbuf[0] = $urandom;
            do_write(addrs[k], 0, 1, 4'hF);
            n_checks++;
            if (w_err !== 1'b0 || w_end !== 1'b0 || w_valid !== 1'b0) begin
                n_fail++; $display("FAIL unsel_write[%h]: got err %b end %b valid %b required 0",
                                   addrs[k], w_err, w_end, w_valid);
            end
        end
        run_read(BASE, 15, '0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_data[i] !== mem[i]) begin
                n_fail++; $display("FAIL unsel_window[%0d]: got %h required %h",
                                   i, cap_data[i], mem[i]);
            end
        end
    endtask

`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
    task automatic test_doorbell();
        run_read(BASE, 0, '0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear_initial: got %b required 0", irq);
        end
        wbuf[0] = $urandom;
        do_write(BASE, 0, 1, 4'b0001);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b required 1", irq);
        end
        do_write(BASE + 32'h4, 0, 1, 4'hF);
        run_read(BASE + 32'h4, 0, '0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_hold_other_word: got %b required 1", irq);
        end
        run_read(BASE, 0, 64'b110);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear_on_read: got %b required 0", irq);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus_idle();
        test_reset();
        test_burst_rw();
        test_byte_merge();
        test_busy();
        test_range_error();
        test_back_to_back();
        test_unselected();
`ifdef SB_DEBUG_MAILBOX_DOORBELL_EN
        test_doorbell();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
